// File: rtl/mem_ext_arb_module.sv
// mem_ext_arb_module
//   Arbiter and sequencer for the single external memory port shared by the
//   MMU page-table walker (PTW), the ICACHE refill path and the DCACHE
//   refill / write-back path. One transaction is outstanding at a time.
//   Read beats are collected into a 4-beat line. Write-back lines are
//   streamed as 4 beats. The owning requester gets a one-cycle done pulse.
//
// Ports
//   clk, rst_n                    core clock, async active-low reset
//   i_flush                       core flush; kills in-flight reads (no done)
//   i_ptw_rden/raddr, o_ptw_done/dat   PTE read (1 beat, bits [31:0])
//   i_ic_rden/raddr, o_ic_done         ICACHE line refill
//   i_dc_rden/raddr, o_dc_rdone        DCACHE line refill
//   i_dc_wren/waddr/wdat, o_dc_wdone   DCACHE line write-back
//   o_line_dat                    assembled read line (beat 0 lowest)
//   o_ext_rden/wren/paddr/burst/mask, i_ext_rdy      burst command
//   o_ext_wdat, o_ext_burst_vld/start/end, i_ext_wrdy write beats
//   i_ext_rvld, i_ext_rdat        read beats
//   o_busy                        transaction in progress
module mem_ext_arb_module #(
  parameter int PADDR_W = 34,
  parameter int BEAT_W  = 128,
  localparam int LINE_W = 4 * BEAT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_ptw_rden,
  input  logic [PADDR_W-1:0] i_ptw_raddr,
  output logic               o_ptw_done,
  output logic [31:0]        o_ptw_dat,
  input  logic               i_ic_rden,
  input  logic [PADDR_W-1:0] i_ic_raddr,
  output logic               o_ic_done,
  input  logic               i_dc_rden,
  input  logic [PADDR_W-1:0] i_dc_raddr,
  input  logic               i_dc_wren,
  input  logic [PADDR_W-1:0] i_dc_waddr,
  input  logic [LINE_W-1:0]  i_dc_wdat,
  output logic               o_dc_rdone,
  output logic               o_dc_wdone,
  output logic [LINE_W-1:0]  o_line_dat,
  output logic               o_ext_rden,
  output logic               o_ext_wren,
  output logic [PADDR_W-1:0] o_ext_paddr,
  output logic [2:0]         o_ext_burst,
  output logic [15:0]        o_ext_mask,
  input  logic               i_ext_rdy,
  output logic [BEAT_W-1:0]  o_ext_wdat,
  output logic               o_ext_burst_vld,
  output logic               o_ext_burst_start,
  output logic               o_ext_burst_end,
  input  logic               i_ext_wrdy,
  input  logic               i_ext_rvld,
  input  logic [BEAT_W-1:0]  i_ext_rdat,
  output logic               o_busy
);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_CMD  = 5'b00010,
    S_RD   = 5'b00100,
    S_WR   = 5'b01000,
    S_DONE = 5'b10000
  } state_e;

  typedef enum logic [1:0] {
    SRC_PTW = 2'd0,
    SRC_IC  = 2'd1,
    SRC_DCR = 2'd2,
    SRC_DCW = 2'd3
  } src_e;

  state_e                   state_q, state_d;
  src_e                     src_q, src_d;
  logic [1:0]               cnt_q, cnt_d;
  logic                     rr_q, rr_d;      // 0: IC wins a read tie, 1: DC wins
  logic                     kill_q, kill_d;
  logic [PADDR_W-1:0]       addr_q, addr_d;
  logic [2:0]               burst_q, burst_d;
  logic [3:0][BEAT_W-1:0]   wline_q, wline_d;
  logic [3:0][BEAT_W-1:0]   line_q;
  logic [31:0]              ptw_dat_q;
  logic                     beat_we;

  logic is_cmd, is_wr, is_done, is_read;
  assign is_cmd  = (state_q == S_CMD);
  assign is_wr   = (state_q == S_WR);
  assign is_done = (state_q == S_DONE);
  assign is_read = (src_q != SRC_DCW);

  // Cache-line requests are forced line-aligned; PTE addresses pass through.
  function automatic logic [PADDR_W-1:0] line_addr(input logic [PADDR_W-1:0] a);
    return {a[PADDR_W-1:6], 6'b0};
  endfunction

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= SRC_PTW;
      cnt_q   <= 2'd0;
      rr_q    <= 1'b0;
      kill_q  <= 1'b0;
      addr_q  <= '0;
      burst_q <= 3'd0;
      wline_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      kill_q  <= kill_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      wline_q <= wline_d;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    kill_d  = kill_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    wline_d = wline_q;
    beat_we = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A flush in IDLE suppresses the grant for that cycle.
        if (!i_flush) begin
          if (i_ptw_rden) begin
            src_d   = SRC_PTW;
            addr_d  = i_ptw_raddr;
            burst_d = 3'd0;
            state_d = S_CMD;
          end else if (i_dc_wren) begin
            src_d   = SRC_DCW;
            addr_d  = line_addr(i_dc_waddr);
            burst_d = 3'd3;
            wline_d = i_dc_wdat;
            state_d = S_CMD;
          end else if (i_ic_rden && (!i_dc_rden || !rr_q)) begin
            src_d   = SRC_IC;
            addr_d  = line_addr(i_ic_raddr);
            burst_d = 3'd3;
            state_d = S_CMD;
            // Pointer only moves when the tie was actually contested.
            if (i_dc_rden) rr_d = 1'b1;
          end else if (i_dc_rden) begin
            src_d   = SRC_DCR;
            addr_d  = line_addr(i_dc_raddr);
            burst_d = 3'd3;
            state_d = S_CMD;
            if (i_ic_rden) rr_d = 1'b0;
          end
        end
      end
      S_CMD: begin
        if (i_ext_rdy) state_d = is_read ? S_RD : S_WR;
      end
      S_RD: begin
        if (i_ext_rvld) begin
          beat_we = 1'b1;
          if (cnt_q == burst_q[1:0]) begin
            cnt_d   = 2'd0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_WR: begin
        if (i_ext_wrdy) begin
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
        kill_d  = 1'b0;
      end
    endcase
    // Killed reads still run to completion on the bus so beats are drained;
    // only the done pulse is dropped. Write-backs are never killed.
    if (i_flush && is_read && (state_q == S_CMD || state_q == S_RD))
      kill_d = 1'b1;
  end

  // ---------------- read data capture ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q    <= '0;
      ptw_dat_q <= 32'd0;
    end else if (beat_we) begin
      if (src_q == SRC_PTW) begin
        if (cnt_q == 2'd0) ptw_dat_q <= i_ext_rdat[31:0];
      end else begin
        line_q[cnt_q] <= i_ext_rdat;
      end
    end
  end

  // ---------------- outputs ----------------
  // A flush arriving in the DONE cycle itself also suppresses the pulse.
  logic rd_done_ok;
  assign rd_done_ok = is_done && !kill_q && !i_flush;

  assign o_ptw_done  = rd_done_ok && (src_q == SRC_PTW);
  assign o_ic_done   = rd_done_ok && (src_q == SRC_IC);
  assign o_dc_rdone  = rd_done_ok && (src_q == SRC_DCR);
  assign o_dc_wdone  = is_done && (src_q == SRC_DCW);
  assign o_ptw_dat   = ptw_dat_q;
  assign o_line_dat  = line_q;

  assign o_ext_rden  = is_cmd && is_read;
  assign o_ext_wren  = is_cmd && !is_read;
  assign o_ext_paddr = is_cmd ? addr_q : '0;
  assign o_ext_burst = is_cmd ? burst_q : 3'd0;
  assign o_ext_mask  = 16'hFFFF;

  assign o_ext_burst_vld   = is_wr;
  assign o_ext_wdat        = is_wr ? wline_q[cnt_q] : '0;
  assign o_ext_burst_start = is_wr && (cnt_q == 2'd0);
  assign o_ext_burst_end   = is_wr && (cnt_q == 2'd3);

  assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_ext_arb_module.sv
// Directed testbench for mem_ext_arb_module: PTW read, IC/DC round-robin,
// priority with write-back and wrdy stalls, read kill on flush, write-back
// immune to flush, and asynchronous reset in the middle of a read.
module tb_mem_ext_arb_module;
  localparam int PADDR_W = 34;
  localparam int BEAT_W  = 128;
  localparam int LINE_W  = 512;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_flush;
  logic               i_ptw_rden;
  logic [PADDR_W-1:0] i_ptw_raddr;
  logic               o_ptw_done;
  logic [31:0]        o_ptw_dat;
  logic               i_ic_rden;
  logic [PADDR_W-1:0] i_ic_raddr;
  logic               o_ic_done;
  logic               i_dc_rden;
  logic [PADDR_W-1:0] i_dc_raddr;
  logic               i_dc_wren;
  logic [PADDR_W-1:0] i_dc_waddr;
  logic [LINE_W-1:0]  i_dc_wdat;
  logic               o_dc_rdone;
  logic               o_dc_wdone;
  logic [LINE_W-1:0]  o_line_dat;
  logic               o_ext_rden;
  logic               o_ext_wren;
  logic [PADDR_W-1:0] o_ext_paddr;
  logic [2:0]         o_ext_burst;
  logic [15:0]        o_ext_mask;
  logic               i_ext_rdy;
  logic [BEAT_W-1:0]  o_ext_wdat;
  logic               o_ext_burst_vld;
  logic               o_ext_burst_start;
  logic               o_ext_burst_end;
  logic               i_ext_wrdy;
  logic               i_ext_rvld;
  logic [BEAT_W-1:0]  i_ext_rdat;
  logic               o_busy;

  mem_ext_arb_module #(.PADDR_W(PADDR_W), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .i_ptw_rden(i_ptw_rden), .i_ptw_raddr(i_ptw_raddr),
    .o_ptw_done(o_ptw_done), .o_ptw_dat(o_ptw_dat),
    .i_ic_rden(i_ic_rden), .i_ic_raddr(i_ic_raddr), .o_ic_done(o_ic_done),
    .i_dc_rden(i_dc_rden), .i_dc_raddr(i_dc_raddr),
    .i_dc_wren(i_dc_wren), .i_dc_waddr(i_dc_waddr), .i_dc_wdat(i_dc_wdat),
    .o_dc_rdone(o_dc_rdone), .o_dc_wdone(o_dc_wdone), .o_line_dat(o_line_dat),
    .o_ext_rden(o_ext_rden), .o_ext_wren(o_ext_wren),
    .o_ext_paddr(o_ext_paddr), .o_ext_burst(o_ext_burst),
    .o_ext_mask(o_ext_mask), .i_ext_rdy(i_ext_rdy),
    .o_ext_wdat(o_ext_wdat), .o_ext_burst_vld(o_ext_burst_vld),
    .o_ext_burst_start(o_ext_burst_start), .o_ext_burst_end(o_ext_burst_end),
    .i_ext_wrdy(i_ext_wrdy), .i_ext_rvld(i_ext_rvld), .i_ext_rdat(i_ext_rdat),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow #1 later.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Entered in the IDLE cycle with i_ptw_rden set; returns in the done cycle.
  task automatic ptw_rd(input string tag, input logic [PADDR_W-1:0] addr,
                        input logic [31:0] dat);
    next(); i_ext_rdy = 1'b1; #1;
    chk({tag, ".rden"},  o_ext_rden, 1'b1);
    chk({tag, ".paddr"}, o_ext_paddr, addr);
    chk({tag, ".burst"}, o_ext_burst, 3'd0);
    next(); i_ext_rdy = 1'b0; i_ext_rvld = 1'b1;
    i_ext_rdat = {96'h5A5A_0000_1111_2222_3333_4444, dat}; #1;
    chk({tag, ".early"}, o_ptw_done, 1'b0);
    next(); i_ext_rvld = 1'b0; i_ext_rdat = '0; #1;
    chk({tag, ".done"}, o_ptw_done, 1'b1);
    chk({tag, ".dat"},  o_ptw_dat, dat);
    i_ptw_rden = 1'b0;
  endtask

  // Entered in the IDLE cycle with the request set; returns in the done cycle.
  task automatic line_rd(input string tag, input bit exp_ic,
                         input logic [PADDR_W-1:0] addr,
                         input logic [3:0][BEAT_W-1:0] beats);
    next(); i_ext_rdy = 1'b1; #1;
    chk({tag, ".rden"},  o_ext_rden, 1'b1);
    chk({tag, ".wren"},  o_ext_wren, 1'b0);
    chk({tag, ".paddr"}, o_ext_paddr, addr);
    chk({tag, ".burst"}, o_ext_burst, 3'd3);
    for (int b = 0; b < 4; b++) begin
      next(); i_ext_rdy = 1'b0; i_ext_rvld = 1'b1; i_ext_rdat = beats[b];
    end
    next(); i_ext_rvld = 1'b0; i_ext_rdat = '0; #1;
    chk({tag, ".icdone"}, o_ic_done, exp_ic);
    chk({tag, ".dcdone"}, o_dc_rdone, !exp_ic);
    chk({tag, ".line"},   o_line_dat, beats);
  endtask

  // Write-back; beat 1 is stalled 2 cycles. flush_beat < 0 means no flush.
  task automatic wr_line(input string tag, input logic [PADDR_W-1:0] addr,
                         input logic [3:0][BEAT_W-1:0] line, input int flush_beat);
    next(); i_ext_rdy = 1'b1; #1;
    chk({tag, ".wren"},  o_ext_wren, 1'b1);
    chk({tag, ".rden"},  o_ext_rden, 1'b0);
    chk({tag, ".paddr"}, o_ext_paddr, addr);
    chk({tag, ".burst"}, o_ext_burst, 3'd3);
    for (int b = 0; b < 4; b++) begin
      int stall;
      stall = (b == 1) ? 2 : 0;
      for (int s = 0; s <= stall; s++) begin
        next(); i_ext_rdy = 1'b0;
        i_ext_wrdy = (s == stall);
        i_flush    = (b == flush_beat) && (s == stall);
        #1;
        chk($sformatf("%s.vld%0d_%0d", tag, b, s),   o_ext_burst_vld, 1'b1);
        chk($sformatf("%s.wdat%0d_%0d", tag, b, s),  o_ext_wdat, line[b]);
        chk($sformatf("%s.start%0d_%0d", tag, b, s), o_ext_burst_start, (b == 0));
        chk($sformatf("%s.end%0d_%0d", tag, b, s),   o_ext_burst_end, (b == 3));
      end
    end
    next(); i_ext_wrdy = 1'b0; i_flush = 1'b0; #1;
    chk({tag, ".wdone"}, o_dc_wdone, 1'b1);
    chk({tag, ".novld"}, o_ext_burst_vld, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][BEAT_W-1:0] beats;
    logic [3:0][BEAT_W-1:0] wl;
    rst_n = 1'b0; i_flush = 1'b0;
    i_ptw_rden = 1'b0; i_ptw_raddr = '0;
    i_ic_rden = 1'b0; i_ic_raddr = '0;
    i_dc_rden = 1'b0; i_dc_raddr = '0;
    i_dc_wren = 1'b0; i_dc_waddr = '0; i_dc_wdat = '0;
    i_ext_rdy = 1'b0; i_ext_wrdy = 1'b0; i_ext_rvld = 1'b0; i_ext_rdat = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", o_busy, 1'b0);
    chk("rst.rden", o_ext_rden, 1'b0);
    chk("rst.wren", o_ext_wren, 1'b0);
    chk("rst.vld",  o_ext_burst_vld, 1'b0);
    chk("rst.line", o_line_dat, '0);
    chk("rst.mask", o_ext_mask, 16'hFFFF);
    chk("rst.done", {o_ptw_done, o_ic_done, o_dc_rdone, o_dc_wdone}, 4'b0);
    rst_n = 1'b1;
    next();

    // ---- PTW read: command cycle 1, beat cycle 2, done cycle 3 ----
    i_ptw_rden = 1'b1; i_ptw_raddr = 34'h0_8000_1004; #1;
    chk("ptw.idle", o_busy, 1'b0);
    ptw_rd("ptw", 34'h0_8000_1004, 32'h2000_0C01);
    next(); #1;
    chk("ptw.after", o_ptw_done, 1'b0);
    chk("ptw.busy",  o_busy, 1'b0);

    // ---- IC and DC reads together for 3 rounds: IC, DC, IC ----
    i_ic_rden = 1'b1; i_ic_raddr = 34'h1_2345_6740;
    i_dc_rden = 1'b1; i_dc_raddr = 34'h2_0000_0080;
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 4; b++)
        beats[b] = {32'hB000_0000 + 32'(r), 32'h0000_00B0 + 32'(b),
                    32'h1357_9BDF, 32'h8000_0000 + 32'(r * 16 + b)};
      line_rd($sformatf("rr%0d", r), (r != 1),
              (r != 1) ? 34'h1_2345_6740 : 34'h2_0000_0080, beats);
      if (r == 2) begin
        i_ic_rden = 1'b0;
        i_dc_rden = 1'b0;
      end
      next();
    end

    // ---- PTW + DC write + IC read together: PTW, DC write, IC ----
    for (int b = 0; b < 4; b++)
      wl[b] = {32'hDC00_0000 + 32'(b), 32'hFEED_BEEF, 32'h0F0F_0F0F, 32'h1000_0000 * 32'(b + 1)};
    i_ptw_rden = 1'b1; i_ptw_raddr = 34'h0_0000_2008;
    i_dc_wren  = 1'b1; i_dc_waddr  = 34'h3_0000_0100; i_dc_wdat = wl;
    i_ic_rden  = 1'b1; i_ic_raddr  = 34'h1_0000_0400;
    ptw_rd("pri.ptw", 34'h0_0000_2008, 32'hCAFE_F00D);
    next();
    wr_line("pri.wr", 34'h3_0000_0100, wl, -1);
    i_dc_wren = 1'b0;
    next();
    for (int b = 0; b < 4; b++)
      beats[b] = {96'h0, 32'hAC00_0000 + 32'(b)};
    line_rd("pri.ic", 1'b1, 34'h1_0000_0400, beats);
    i_ic_rden = 1'b0;
    next();

    // ---- IC read flushed after beat 1: drained, no done ----
    i_ic_rden = 1'b1; i_ic_raddr = 34'h0_0ABC_0000;
    next(); i_ext_rdy = 1'b1; #1;
    chk("kill.rden", o_ext_rden, 1'b1);
    next(); i_ext_rdy = 1'b0; i_ext_rvld = 1'b1; i_ext_rdat = 128'h10;
    next(); i_ext_rdat = 128'h11;
    next(); i_ext_rdat = 128'h12; i_flush = 1'b1;
    next(); i_ext_rdat = 128'h13; i_flush = 1'b0; #1;
    chk("kill.drain", o_busy, 1'b1);
    next(); i_ext_rvld = 1'b0; i_ext_rdat = '0; #1;
    chk("kill.nodone", o_ic_done, 1'b0);
    chk("kill.busy",   o_busy, 1'b1);
    i_ic_rden = 1'b0;
    next(); #1;
    chk("kill.idle", o_busy, 1'b0);
    i_dc_rden = 1'b1; i_dc_raddr = 34'h2_FFFF_FFC0;
    for (int b = 0; b < 4; b++)
      beats[b] = {32'hD0D0_0000 + 32'(b), 96'h0123_4567_89AB_CDEF_0000_0001};
    line_rd("kill.next", 1'b0, 34'h2_FFFF_FFC0, beats);
    i_dc_rden = 1'b0;
    next();

    // ---- DC write with flush mid-burst: not killed ----
    for (int b = 0; b < 4; b++)
      wl[b] = {4{32'hE000_0000 + 32'(b)}};
    i_dc_wren = 1'b1; i_dc_waddr = 34'h1_8000_0040; i_dc_wdat = wl;
    wr_line("wflush", 34'h1_8000_0040, wl, 2);
    i_dc_wren = 1'b0;
    next();

    // ---- async reset in the middle of a read ----
    i_ic_rden = 1'b1; i_ic_raddr = 34'h0_1111_1100;
    next(); i_ext_rdy = 1'b1;
    next(); i_ext_rdy = 1'b0; i_ext_rvld = 1'b1; i_ext_rdat = 128'hAA;
    next(); i_ext_rdat = 128'hBB;
    next(); rst_n = 1'b0; i_ext_rvld = 1'b0; i_ext_rdat = '0; i_ic_rden = 1'b0; #1;
    chk("mrst.busy", o_busy, 1'b0);
    chk("mrst.rden", o_ext_rden, 1'b0);
    chk("mrst.line", o_line_dat, '0);
    chk("mrst.done", {o_ptw_done, o_ic_done, o_dc_rdone, o_dc_wdone}, 4'b0);
    chk("mrst.mask", o_ext_mask, 16'hFFFF);
    next(); rst_n = 1'b1;
    next();
    i_ptw_rden = 1'b1; i_ptw_raddr = 34'h2_0000_0FF8;
    ptw_rd("mrst.ptw", 34'h2_0000_0FF8, 32'h0BAD_C0DE);
    next(); #1;
    chk("mrst.idle", o_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
